// File: rtl/axi_pkg.sv
// Shared AXI helpers: width derivations used to size remap ID fields
// identically in the parent remap datapath and the ID allocation table.
package axi_pkg;

  function automatic int unsigned iw_cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

  function automatic int unsigned iw_idx_width(input int unsigned n_ids);
    return (n_ids > 1) ? $clog2(n_ids) : 1;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter (MODE=0: trailing zeros, i.e. lowest set index).
// cnt_o is 0 when the input is all zero.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    // Scan ordered so that the winning bit is the last one assigned.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MODE) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end else begin
        if (in_i[WIDTH - 1 - i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder; all-zero input encodes to 0.
module onehot_to_bin #(
  parameter int unsigned ONEHOT_WIDTH = 16,
  parameter int unsigned BIN_WIDTH    = (ONEHOT_WIDTH > 1) ? $clog2(ONEHOT_WIDTH) : 1
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot,
  output logic [BIN_WIDTH-1:0]    bin
);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot[i]) bin = bin | BIN_WIDTH'(i);
    end
  end

endmodule

// File: rtl/axi_iw_id_alloc.sv
// Remap-mode ID allocation table: maps live slave-port IDs to master-port IDs
// (table indices) and counts outstanding transactions per entry.
module axi_iw_id_alloc
  import axi_pkg::*;
#(
  parameter int unsigned  InpIdWidth    = 4,
  parameter int unsigned  MaxUniqInpIds = 4,
  parameter int unsigned  MaxTxnsPerId  = 4,
  localparam int unsigned IdxWidth      = iw_idx_width(MaxUniqInpIds)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic [IdxWidth-1:0]   free_oup_id_o,
  input  logic [InpIdWidth-1:0] exists_inp_id_i,
  output logic                  exists_o,
  output logic [IdxWidth-1:0]   exists_oup_id_o,
  output logic                  exists_full_o,
  input  logic                  push_i,
  input  logic [InpIdWidth-1:0] push_inp_id_i,
  input  logic [IdxWidth-1:0]   push_oup_id_i,
  input  logic                  pop_i,
  input  logic [IdxWidth-1:0]   pop_oup_id_i,
  output logic [InpIdWidth-1:0] pop_inp_id_o
);

  localparam int unsigned           CntWidth = iw_cnt_width(MaxTxnsPerId);
  localparam logic [CntWidth-1:0]   CntMax   = CntWidth'(MaxTxnsPerId);
  localparam logic [CntWidth-1:0]   CntOne   = CntWidth'(1);

  typedef struct packed {
    logic [InpIdWidth-1:0] inp_id;
    logic [CntWidth-1:0]   cnt;
  } entry_t;

  entry_t [MaxUniqInpIds-1:0] tbl_q, tbl_d;
  logic   [MaxUniqInpIds-1:0] free, match;

  always_comb begin
    tbl_d         = tbl_q;
    free          = '0;
    match         = '0;
    exists_full_o = 1'b0;
    pop_inp_id_o  = '0;
    for (int unsigned i = 0; i < MaxUniqInpIds; i++) begin
      free[i]  = (tbl_q[i].cnt == '0);
      match[i] = !free[i] && (tbl_q[i].inp_id == exists_inp_id_i);
      if (match[i] && (tbl_q[i].cnt == CntMax)) exists_full_o = 1'b1;
      if (pop_oup_id_i == IdxWidth'(i)) pop_inp_id_o = tbl_q[i].inp_id;
      // A same-entry push and pop cancel; inp_id is only loaded into a free entry.
      if (push_i && (push_oup_id_i == IdxWidth'(i)) &&
          !(pop_i && (pop_oup_id_i == IdxWidth'(i)))) begin
        if (free[i]) tbl_d[i].inp_id = push_inp_id_i;
        tbl_d[i].cnt = tbl_q[i].cnt + CntOne;
      end else if (pop_i && (pop_oup_id_i == IdxWidth'(i)) &&
                   !(push_i && (push_oup_id_i == IdxWidth'(i)))) begin
        tbl_d[i].cnt = tbl_q[i].cnt - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign exists_o = |match;

  lzc #(
    .WIDTH    (MaxUniqInpIds),
    .MODE     (1'b0),
    .CNT_WIDTH(IdxWidth)
  ) i_free_lzc (
    .in_i   (free),
    .cnt_o  (free_oup_id_o),
    .empty_o(full_o)
  );

  onehot_to_bin #(
    .ONEHOT_WIDTH(MaxUniqInpIds),
    .BIN_WIDTH   (IdxWidth)
  ) i_match_enc (
    .onehot(match),
    .bin   (exists_oup_id_o)
  );

`ifndef SYNTHESIS
  logic [CntWidth-1:0] push_cnt, pop_cnt;
  logic                push_live;

  always_comb begin
    push_cnt  = '0;
    pop_cnt   = '0;
    push_live = 1'b0;
    for (int unsigned i = 0; i < MaxUniqInpIds; i++) begin
      if (push_oup_id_i == IdxWidth'(i)) push_cnt = tbl_q[i].cnt;
      if (pop_oup_id_i == IdxWidth'(i)) pop_cnt = tbl_q[i].cnt;
      if ((tbl_q[i].cnt != '0) && (tbl_q[i].inp_id == push_inp_id_i)) push_live = 1'b1;
    end
  end

  a_push_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> (32'(push_oup_id_i) < MaxUniqInpIds));
  a_pop_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_i |-> (32'(pop_oup_id_i) < MaxUniqInpIds));
  a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i && (push_cnt == CntMax)) |-> (pop_i && (pop_oup_id_i == push_oup_id_i)));
  a_push_dup: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i && (push_cnt == '0)) |-> !push_live);
  a_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_i |-> (pop_cnt != '0));
`endif

endmodule

// File: tb/tb_axi_iw_id_alloc.sv
// Scoreboard bench for axi_iw_id_alloc: driver queues expected outputs per
// cycle, an independent monitor samples the DUT mid-cycle and compares.
module tb_axi_iw_id_alloc;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       full_o, exists_o, exists_full_o;
  logic [1:0] free_oup_id_o, exists_oup_id_o;
  logic [3:0] exists_inp_id_i, push_inp_id_i, pop_inp_id_o;
  logic       push_i, pop_i;
  logic [1:0] push_oup_id_i, pop_oup_id_i;

  always #5 clk = ~clk;

  axi_iw_id_alloc #(
    .InpIdWidth   (4),
    .MaxUniqInpIds(4),
    .MaxTxnsPerId (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .full_o         (full_o),
    .free_oup_id_o  (free_oup_id_o),
    .exists_inp_id_i(exists_inp_id_i),
    .exists_o       (exists_o),
    .exists_oup_id_o(exists_oup_id_o),
    .exists_full_o  (exists_full_o),
    .push_i         (push_i),
    .push_inp_id_i  (push_inp_id_i),
    .push_oup_id_i  (push_oup_id_i),
    .pop_i          (pop_i),
    .pop_oup_id_i   (pop_oup_id_i),
    .pop_inp_id_o   (pop_inp_id_o)
  );

  typedef struct {
    string      name;
    logic       full;
    logic [1:0] free;
    logic       ex;
    logic [1:0] exid;
    logic       exfull;
    logic [3:0] pinp;
  } exp_t;

  exp_t sb[$];
  logic chk_valid = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: samples 2 time units after each falling edge, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (chk_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_underflow actual=empty required=entry");
        end else begin
          e = sb.pop_front();
          cmp(e.name, "full_o", 8'(full_o), 8'(e.full));
          if (!e.full) cmp(e.name, "free_oup_id_o", 8'(free_oup_id_o), 8'(e.free));
          cmp(e.name, "exists_o", 8'(exists_o), 8'(e.ex));
          cmp(e.name, "exists_oup_id_o", 8'(exists_oup_id_o), 8'(e.exid));
          cmp(e.name, "exists_full_o", 8'(exists_full_o), 8'(e.exfull));
          cmp(e.name, "pop_inp_id_o", 8'(pop_inp_id_o), 8'(e.pinp));
        end
      end
    end
  end

  task automatic cyc(input logic ps, input logic [3:0] pi, input logic [1:0] po,
                     input logic pp, input logic [1:0] pd, input logic [3:0] lk);
    @(negedge clk);
    push_i          = ps;
    push_inp_id_i   = pi;
    push_oup_id_i   = po;
    pop_i           = pp;
    pop_oup_id_i    = pd;
    exists_inp_id_i = lk;
    chk_valid       = 1'b0;
  endtask

  task automatic exp_out(input string nm, input logic f, input logic [1:0] fr, input logic ex,
                         input logic [1:0] exid, input logic exf, input logic [3:0] pinp);
    exp_t e;
    e.name = nm; e.full = f; e.free = fr; e.ex = ex;
    e.exid = exid; e.exfull = exf; e.pinp = pinp;
    sb.push_back(e);
    chk_valid = 1'b1;
  endtask

  // Reference model for the random phase
  logic [3:0]  m_id[4];
  int unsigned m_cnt[4];
  logic [3:0]  r_pid, r_lk;
  logic [1:0]  r_pd, r_po, e_free, e_exid;
  logic        r_pop, r_push, e_full, e_ex, e_exf;
  int          r_m, r_f;
  int unsigned r_k;

  initial begin
    rst_ni = 1'b0;
    push_i = 1'b0; push_inp_id_i = '0; push_oup_id_i = '0;
    pop_i = 1'b0; pop_oup_id_i = '0; exists_inp_id_i = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    cyc(0, 4'h0, 0, 0, 0, 4'hA); exp_out("reset_idle", 0, 0, 0, 0, 0, 4'h0);
    cyc(1, 4'hA, 0, 0, 0, 4'hA); exp_out("push_a_pre", 0, 0, 0, 0, 0, 4'h0);
    cyc(0, 4'h0, 0, 0, 0, 4'hA); exp_out("lookup_a", 0, 1, 1, 0, 0, 4'hA);
    repeat (3) cyc(1, 4'hA, 0, 0, 0, 4'hA);
    cyc(0, 4'h0, 0, 0, 0, 4'hA); exp_out("exists_full", 0, 1, 1, 0, 1, 4'hA);
    cyc(0, 4'h0, 0, 1, 0, 4'hA); exp_out("pop_at_full", 0, 1, 1, 0, 1, 4'hA);
    cyc(0, 4'h0, 0, 0, 0, 4'hA); exp_out("pop_once", 0, 1, 1, 0, 0, 4'hA);
    repeat (3) cyc(0, 4'h0, 0, 1, 0, 4'hA);
    cyc(0, 4'h0, 0, 0, 0, 4'hA); exp_out("retained", 0, 0, 0, 0, 0, 4'hA);

    cyc(1, 4'h1, 0, 0, 0, 4'h4);
    cyc(1, 4'h2, 1, 0, 0, 4'h4);
    cyc(1, 4'h3, 2, 0, 0, 4'h4);
    cyc(1, 4'h4, 3, 0, 0, 4'h4); exp_out("fourth_push_pre", 0, 3, 0, 0, 0, 4'h1);
    cyc(0, 4'h0, 0, 0, 2, 4'h4); exp_out("full", 1, 0, 1, 3, 0, 4'h3);
    cyc(0, 4'h0, 0, 1, 2, 4'h3); exp_out("pop_e2_pre", 1, 0, 1, 2, 0, 4'h3);
    cyc(0, 4'h0, 0, 0, 2, 4'h3); exp_out("freed_e2", 0, 2, 0, 0, 0, 4'h3);

    cyc(1, 4'h2, 1, 0, 0, 4'h2);
    cyc(1, 4'h2, 1, 1, 1, 4'h2); exp_out("push_pop_same", 0, 2, 1, 1, 0, 4'h2);
    cyc(0, 4'h0, 0, 1, 1, 4'h2);
    cyc(0, 4'h0, 0, 1, 1, 4'h2); exp_out("last_pop_e1", 0, 2, 1, 1, 0, 4'h2);
    cyc(0, 4'h0, 0, 0, 1, 4'h2); exp_out("same_cnt_kept", 0, 1, 0, 0, 0, 4'h2);

    cyc(1, 4'h1, 0, 1, 3, 4'h4); exp_out("push_pop_diff", 0, 1, 1, 3, 0, 4'h4);
    cyc(0, 4'h0, 0, 0, 3, 4'h4); exp_out("pop_diff_e3", 0, 1, 0, 0, 0, 4'h4);
    cyc(0, 4'h0, 0, 1, 0, 4'h1);
    cyc(0, 4'h0, 0, 0, 0, 4'h1); exp_out("push_diff_cnt", 0, 1, 1, 0, 0, 4'h1);

    cyc(1, 4'h5, 1, 0, 0, 4'h0);
    cyc(1, 4'h6, 2, 0, 0, 4'h0);
    cyc(1, 4'h7, 3, 0, 0, 4'h5); exp_out("pre_reset", 0, 3, 1, 1, 0, 4'h1);
    cyc(0, 4'h0, 0, 0, 1, 4'h5);
    #1 rst_ni = 1'b0;
    exp_out("reset_mid", 0, 0, 0, 0, 0, 4'h0);
    cyc(0, 4'h0, 0, 0, 1, 4'h5);
    rst_ni = 1'b1;
    exp_out("after_reset", 0, 0, 0, 0, 0, 4'h0);

    for (int j = 0; j < 4; j++) begin m_id[j] = '0; m_cnt[j] = 0; end
    for (int n = 0; n < 300; n++) begin
      r_pid = 4'($urandom_range(1, 6));
      r_lk  = 4'($urandom_range(0, 7));
      r_pop = 1'b0;
      r_pd  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        r_k = $urandom_range(0, 3);
        for (int unsigned t = 0; t < 4; t++) begin
          if (!r_pop && m_cnt[(r_k + t) % 4] != 0) begin
            r_pop = 1'b1;
            r_pd  = 2'((r_k + t) % 4);
          end
        end
      end
      r_push = 1'b0; r_po = '0;
      if ($urandom_range(0, 2) != 0) begin
        r_m = -1;
        for (int j = 0; j < 4; j++) if (m_cnt[j] != 0 && m_id[j] == r_pid) r_m = j;
        if (r_m >= 0) begin
          if (m_cnt[r_m] < 4 || (r_pop && r_pd == 2'(r_m))) begin r_push = 1'b1; r_po = 2'(r_m); end
        end else begin
          r_f = -1;
          for (int j = 3; j >= 0; j--) if (m_cnt[j] == 0) r_f = j;
          if (r_f >= 0) begin r_push = 1'b1; r_po = 2'(r_f); end
        end
      end
      e_full = 1'b1; e_free = '0; e_ex = 1'b0; e_exid = '0; e_exf = 1'b0;
      for (int j = 3; j >= 0; j--) if (m_cnt[j] == 0) begin e_full = 1'b0; e_free = 2'(j); end
      for (int j = 0; j < 4; j++) begin
        if (m_cnt[j] != 0 && m_id[j] == r_lk) begin
          e_ex = 1'b1; e_exid = 2'(j); e_exf = (m_cnt[j] == 4);
        end
      end
      cyc(r_push, r_pid, r_po, r_pop, r_pd, r_lk);
      exp_out("random", e_full, e_free, e_ex, e_exid, e_exf, m_id[r_pd]);
      for (int j = 0; j < 4; j++) begin
        if (r_push && r_po == 2'(j) && !(r_pop && r_pd == 2'(j))) begin
          if (m_cnt[j] == 0) m_id[j] = r_pid;
          m_cnt[j]++;
        end else if (r_pop && r_pd == 2'(j) && !(r_push && r_po == 2'(j))) begin
          m_cnt[j]--;
        end
      end
    end

    repeat (2) cyc(0, 4'h0, 0, 0, 0, 4'h0);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
